// File: rtl/noc_arbiter.sv
// Round-robin scheduler for the four NoC FIFOs. It issues one router transfer
// request (src/dest/valid) per slot, then holds off while the router moves the
// packet and the FIFO flags settle.
module noc_arbiter #(
    parameter int unsigned GAP = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [3:0]  fifo_empty,
    input  logic [3:0]  fifo_full,
    input  logic [1:0]  req_dest_0,
    input  logic [1:0]  req_dest_1,
    input  logic [1:0]  req_dest_2,
    input  logic [1:0]  req_dest_3,
    output logic [1:0]  src,
    output logic [1:0]  dest,
    output logic        valid,
    output logic        busy,
    output logic [15:0] grant_count,
    output logic        self_route_err
);

    localparam int unsigned NUM_FIFO = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned CNT_W    = 4;
    localparam int unsigned GCNT_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    src_q, src_d;
    logic [IDX_W-1:0]    dest_q, dest_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic [GCNT_W-1:0]   gcnt_q, gcnt_d;
    logic                err_q, err_d;

    logic [IDX_W-1:0]    req_dest [NUM_FIFO];
    logic [NUM_FIFO-1:0] self_c;
    logic [NUM_FIFO-1:0] elig_c;
    logic                found_c;
    logic [IDX_W-1:0]    win_c;

    assign req_dest[0] = req_dest_0;
    assign req_dest[1] = req_dest_1;
    assign req_dest[2] = req_dest_2;
    assign req_dest[3] = req_dest_3;

    // Per-FIFO self-route detection and grant eligibility
    always_comb begin
        self_c = '0;
        elig_c = '0;
        for (int unsigned i = 0; i < NUM_FIFO; i++) begin
            self_c[i] = !fifo_empty[i] && (req_dest[i] == IDX_W'(i));
            elig_c[i] = en && !fifo_empty[i] && !fifo_full[req_dest[i]] && !self_c[i];
        end
    end

    // Rotating search starting at ptr; first eligible index wins
    always_comb begin
        logic [IDX_W-1:0] idx;
        found_c = 1'b0;
        win_c   = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_FIFO; k++) begin
            idx = ptr_q + IDX_W'(k);
            if (!found_c && elig_c[idx]) begin
                found_c = 1'b1;
                win_c   = idx;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            src_q   <= '0;
            dest_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            gcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            dest_q  <= dest_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            gcnt_q  <= gcnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: grant from IDLE, count in GRANT, wait out the hold-off in HOLD
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        src_d   = src_q;
        dest_d  = dest_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        gcnt_d  = gcnt_q;
        err_d   = err_q | (|self_c);

        unique case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = GRANT;
                    src_d   = win_c;
                    dest_d  = req_dest[win_c];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    ptr_d   = win_c + IDX_W'(1);
                end
            end
            GRANT: begin
                gcnt_d  = gcnt_q + GCNT_W'(1);
                cnt_d   = CNT_W'(GAP);
                state_d = HOLD;
            end
            HOLD: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    assign src            = src_q;
    assign dest           = dest_q;
    assign valid          = valid_q;
    assign busy           = busy_q;
    assign grant_count    = gcnt_q;
    assign self_route_err = err_q;

endmodule

// File: tb/tb_noc_arbiter.sv
// Bench for noc_arbiter: reference model compared every cycle, a vector table
// evaluated from reset, directed multi-cycle sequences and random traffic.
module tb_noc_arbiter;

    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  fifo_empty;
    logic [3:0]  fifo_full;
    logic [1:0]  rd0, rd1, rd2, rd3;
    logic [1:0]  src, dest;
    logic        valid, busy;
    logic [15:0] grant_count;
    logic        self_route_err;

    int nerr = 0;
    int nchk = 0;
    bit chk_on = 1'b0;

    noc_arbiter #(.GAP(GAP)) dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .req_dest_0     (rd0),
        .req_dest_1     (rd1),
        .req_dest_2     (rd2),
        .req_dest_3     (rd3),
        .src            (src),
        .dest           (dest),
        .valid          (valid),
        .busy           (busy),
        .grant_count    (grant_count),
        .self_route_err (self_route_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] dst(input int i);
        case (i)
            0:       return rd0;
            1:       return rd1;
            2:       return rd2;
            default: return rd3;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // Grant slots: when no slot is in progress, pick the first eligible FIFO
    // from ptr onward; a slot then occupies GAP+1 busy cycles.
    int          m_left;
    int          m_ptr;
    logic        m_valid;
    logic [1:0]  m_src, m_dest;
    logic [15:0] m_cnt;
    logic        m_err;

    function automatic int pick();
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (en && !fifo_empty[i] && !fifo_full[dst(i)] && dst(i) != 2'(i))
                return i;
        end
        return -1;
    endfunction

    function automatic bit any_self();
        for (int i = 0; i < 4; i++)
            if (!fifo_empty[i] && dst(i) == 2'(i)) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left  <= 0;
            m_ptr   <= 0;
            m_valid <= 1'b0;
            m_src   <= 2'd0;
            m_dest  <= 2'd0;
            m_cnt   <= 16'd0;
            m_err   <= 1'b0;
        end else begin
            if (m_left == 0) begin
                if (pick() >= 0) begin
                    m_valid <= 1'b1;
                    m_src   <= 2'(pick());
                    m_dest  <= dst(pick());
                    m_ptr   <= (pick() + 1) % 4;
                    m_left  <= GAP + 1;
                end else begin
                    m_valid <= 1'b0;
                end
            end else begin
                if (m_valid) m_cnt <= m_cnt + 16'd1;
                m_valid <= 1'b0;
                m_left  <= m_left - 1;
            end
            if (any_self()) m_err <= 1'b1;
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("valid",  32'(valid),          32'(m_valid));
            chk("src",    32'(src),            32'(m_src));
            chk("dest",   32'(dest),           32'(m_dest));
            chk("busy",   32'(busy),           32'(m_left > 0));
            chk("gcount", 32'(grant_count),    32'(m_cnt));
            chk("err",    32'(self_route_err), 32'(m_err));
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_dests(input logic [7:0] d);
        rd0 = d[1:0];
        rd1 = d[3:2];
        rd2 = d[5:4];
        rd3 = d[7:6];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string nm, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!valid && n < max);
        if (!valid) begin
            nchk++;
            nerr++;
            $display("FAIL %s: no valid within %0d cycles", nm, max);
        end
    endtask

    typedef struct {
        logic       en;
        logic [3:0] empty;
        logic [3:0] full;
        logic [7:0] dests;
        logic       exp_valid;
        logic [1:0] exp_src;
        logic [1:0] exp_dest;
        logic       exp_err;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n;
        rst = 1'b1;
        en = 1'b0;
        fifo_empty = 4'hF;
        fifo_full = 4'h0;
        set_dests(8'h00);

        // Expected grant one cycle after inputs are applied from reset (ptr=0)
        tbl[0] = '{1'b1, 4'b1101, 4'b0000, 8'b00_00_11_00, 1'b1, 2'd1, 2'd3, 1'b0};
        tbl[1] = '{1'b0, 4'b1101, 4'b0000, 8'b00_00_11_00, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[2] = '{1'b1, 4'b0000, 4'b0000, 8'b00_11_10_01, 1'b1, 2'd0, 2'd1, 1'b0};
        tbl[3] = '{1'b1, 4'b1100, 4'b0100, 8'b00_00_11_10, 1'b1, 2'd1, 2'd3, 1'b0};
        tbl[4] = '{1'b1, 4'b1011, 4'b0000, 8'b00_10_00_00, 1'b0, 2'd0, 2'd0, 1'b1};
        tbl[5] = '{1'b1, 4'b0000, 4'b0000, 8'b00_11_01_00, 1'b1, 2'd2, 2'd3, 1'b1};
        tbl[6] = '{1'b1, 4'b1111, 4'b0000, 8'b00_11_10_01, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[7] = '{1'b1, 4'b0111, 4'b0010, 8'b01_00_00_00, 1'b0, 2'd0, 2'd0, 1'b0};
        tbl[8] = '{1'b0, 4'b1011, 4'b0000, 8'b00_10_00_00, 1'b0, 2'd0, 2'd0, 1'b1};
        tbl[9] = '{1'b1, 4'b0110, 4'b0000, 8'b11_00_00_11, 1'b1, 2'd0, 2'd3, 1'b1};

        // Reset state
        step();
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_src",   32'(src), 0);
        chk("rst_dest",  32'(dest), 0);
        chk("rst_gcnt",  32'(grant_count), 0);
        chk("rst_err",   32'(self_route_err), 0);
        chk_on = 1'b1;
        rst = 1'b0;

        // Vector table
        for (int v = 0; v < 10; v++) begin
            do_reset();
            en = tbl[v].en;
            fifo_empty = tbl[v].empty;
            fifo_full = tbl[v].full;
            set_dests(tbl[v].dests);
            step();
            chk($sformatf("tbl%0d_valid", v), 32'(valid), 32'(tbl[v].exp_valid));
            chk($sformatf("tbl%0d_src", v),   32'(src),   32'(tbl[v].exp_src));
            chk($sformatf("tbl%0d_dest", v),  32'(dest),  32'(tbl[v].exp_dest));
            chk($sformatf("tbl%0d_err", v),   32'(self_route_err), 32'(tbl[v].exp_err));
        end

        // Single request: one-cycle pulse, busy for 1+GAP cycles, repeat on 4th cycle
        do_reset();
        en = 1'b1; fifo_full = 4'h0; fifo_empty = 4'b1101; set_dests(8'b00_00_11_00);
        step();
        chk("single_valid", 32'(valid), 1);
        chk("single_src",   32'(src), 1);
        chk("single_dest",  32'(dest), 3);
        step();
        chk("single_pulse", 32'(valid), 0);
        chk("single_busy1", 32'(busy), 1);
        chk("single_gcnt",  32'(grant_count), 1);
        step();
        chk("single_busy2", 32'(busy), 1);
        step();
        chk("single_idle",  32'(busy), 0);
        step();
        chk("single_again", 32'(valid), 1);

        // Round-robin fairness
        do_reset();
        fifo_empty = 4'h0; set_dests(8'b00_11_10_01);
        for (int k = 0; k < 5; k++) begin
            wait_valid("rr", 8, n);
            chk($sformatf("rr%0d_src", k), 32'(src), 32'(k % 4));
            if (k > 0) chk($sformatf("rr%0d_period", k), 32'(n), 32'(GAP + 2));
        end
        step();
        chk("rr_gcnt", 32'(grant_count), 5);

        // Destination full: only FIFO1 goes, then wrap search picks FIFO0
        do_reset();
        fifo_empty = 4'b1100; set_dests(8'b00_00_11_10); fifo_full = 4'b0100;
        wait_valid("full1", 4, n);
        chk("full1_src", 32'(src), 1);
        step();
        fifo_full = 4'h0;
        wait_valid("full2", 8, n);
        chk("full2_src", 32'(src), 0);

        // Self-route: never granted, sticky until reset
        do_reset();
        fifo_empty = 4'b1011; set_dests(8'b00_10_00_00);
        repeat (6) begin
            step();
            chk("self_novalid", 32'(valid), 0);
        end
        chk("self_err", 32'(self_route_err), 1);
        fifo_empty = 4'hF;
        repeat (3) step();
        chk("self_sticky", 32'(self_route_err), 1);
        do_reset();
        chk("self_clr", 32'(self_route_err), 0);

        // Enable dropped during HOLD: slot completes, no further grants
        fifo_empty = 4'h0; set_dests(8'b00_11_10_01);
        wait_valid("en", 4, n);
        step();
        en = 1'b0;
        repeat (8) begin
            step();
            chk("en_off_valid", 32'(valid), 0);
        end
        chk("en_off_busy", 32'(busy), 0);
        en = 1'b1;

        // Reset asserted in the GRANT cycle
        do_reset();
        wait_valid("rstg_a", 4, n);
        wait_valid("rstg_b", 8, n);
        chk("rstg_pre_src", 32'(src), 1);
        rst = 1'b1;
        #1;
        chk("rstg_valid", 32'(valid), 0);
        chk("rstg_busy",  32'(busy), 0);
        chk("rstg_gcnt",  32'(grant_count), 0);
        step();
        rst = 1'b0;
        wait_valid("rstg_post", 4, n);
        chk("rstg_post_src", 32'(src), 0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) do_reset();
            en = ($urandom % 8) != 0;
            fifo_empty = 4'($urandom);
            fifo_full = ($urandom % 3 == 0) ? 4'($urandom) : 4'h0;
            set_dests(8'($urandom));
            step();
        end

        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/noc_arbiter.md
# noc_arbiter

Round-robin transfer scheduler that drives the router's `src`/`dest`/`valid` request interface. It watches the empty/full flags and per-FIFO destination requests of the four NoC FIFOs, then picks one eligible source per slot. It issues a single-cycle `valid` pulse and holds off long enough for the router's two-cycle read/write transfer to finish and the FIFO flags to settle.

## Interface
- `GAP`, 2, hold-off cycles after each `valid` pulse (legal 1..15)
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  arbitration enable; sampled only in IDLE
- `fifo_empty`  in  4  empty flag per FIFO (bit i = FIFO i)
- `fifo_full`  in  4  full flag per FIFO
- `req_dest_0..req_dest_3`  in  2 each  requested destination of the head packet of FIFO i
- `src`  out  2  source FIFO index to router, registered
- `dest`  out  2  destination FIFO index to router, registered
- `valid`  out  1  transfer request pulse to router, registered
- `busy`  out  1  high in GRANT and HOLD
- `grant_count`  out  16  number of `valid` pulses issued, wraps at 65535→0
- `self_route_err`  out  1  sticky; set when a non-empty FIFO requests itself as destination

## Operation
- Reset values: `src`=0, `dest`=0, `valid`=0, `busy`=0, `grant_count`=0, `self_route_err`=0, round-robin pointer `ptr`=0, state IDLE, hold counter 0.
- Eligibility of FIFO i: `en` && !`fifo_empty[i]` && !`fifo_full[req_dest_i]` && `req_dest_i` != i.
- Search order from IDLE: ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first eligible index wins.
- FSM:
  - IDLE: if any index is eligible → GRANT. Register `src`=winner, `dest`=`req_dest_winner`, set `valid`=1, `busy`=1, `ptr`=winner+1 (mod 4). Otherwise stay; `valid`=0.
  - GRANT (one cycle, `valid`=1): `grant_count`+=1. → HOLD, counter=GAP, `valid`=0.
  - HOLD: decrement counter. When it reaches 1 → IDLE, `busy`=0. `src`/`dest` stay stable through HOLD.
- `en` deasserted during GRANT/HOLD does not abort; the FSM completes to IDLE, then stops granting.
- `self_route_err`: set in any cycle where !`fifo_empty[i]` && `req_dest_i`==i for some i. Cleared only by `rst`. That FIFO is never granted.
- Ineligible FIFOs, including those whose destination is full, are skipped without moving `ptr`. `ptr` advances only on a grant.
- Flag or request inputs that change during GRANT/HOLD are ignored until the next IDLE evaluation.

## Timing
- Arbitration latency: eligible in IDLE at edge E → `valid` high for exactly the cycle after E.
- `valid` width is always exactly 1 cycle. It is never asserted while the router is processing.
- Back-to-back grant period is GAP+2 cycles: 1 GRANT + GAP HOLD + 1 IDLE. With GAP=2 the period is 4 cycles, which meets the router's minimum 2-cycle spacing.
- `src`/`dest` are valid from the `valid` cycle until the next IDLE→GRANT transition.
- `rst` mid-operation: all outputs return to reset values asynchronously and `valid` drops immediately. The router sees no pulse afterwards until IDLE evaluation after `rst` release.
- `grant_count` updates on the edge ending the GRANT cycle. It reads +1 from the first HOLD cycle.

## Test plan
- Single request: `fifo_empty`=4'b1101, `req_dest_1`=3, `fifo_full`=0, `en`=1 → `valid` one cycle with `src`=1, `dest`=3; `busy` for 1+GAP cycles; `grant_count`=1; next grant on the 4th cycle after the first if the request persists.
- Round-robin fairness: all FIFOs non-empty, `req_dest_i`=(i+1)%4, never full → `src` sequence 0,1,2,3,0; pulses exactly 4 cycles apart (GAP=2); `grant_count`=5 after 5 pulses.
- Destination full: FIFO0→2 and FIFO1→3, `fifo_full`=4'b0100 → only `src`=1 granted and `ptr` becomes 2. After `fifo_full`=0 the next grant is `src`=0 (wrap search 2,3,0).
- Self-route: `fifo_empty`=4'b1011, `req_dest_2`=2 → no `valid` ever; `self_route_err`=1 and stays 1 after FIFO2 empties; cleared by `rst`.
- Enable and reset mid-op: drop `en` during HOLD → current HOLD completes, then no further `valid`. Separately, assert `rst` in the GRANT cycle → `valid`=0, `busy`=0, `grant_count`=0, `ptr`=0 immediately; first post-reset grant uses search order 0,1,2,3.
- Counter wrap: preload by running 65536 grants (or force) → `grant_count` wraps 65535→0 with no effect on `valid` timing.
